tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Programmable clock-enable generator that replaces the ripple-clock chain in game logic.
//  Produces NUM_CH single-cycle tick strobes on the main clock, each at its own divide ratio.
//  Game subsystems (sprite animation, input poll, audio step, score blink) gate on tick[i]
//  rather than on derived clocks.
//  A valid/ready config port reprograms a channel; the new ratio lands only at a period boundary.
// PARAMETERS
//  NUM_CH  4   number of tick channels (1..16)
//  DIV_W   16  width of divide value; max period 2**DIV_W-1 cycles
//  CH_W    $clog2(NUM_CH) (min 1)  channel-select width, derived (localparam)
// PORTS
//  clk         in   1           system clock; all logic on posedge
//  reset       in   1           asynchronous, active-low reset
//  run         in   1           global run; 0 freezes all channel counters
//  cfg_valid   in   1           config request valid
//  cfg_ready   out  1           config port can accept
//  cfg_ch      in   CH_W        target channel
//  cfg_div     in   DIV_W       divide value D; tick every D cycles; 0 = channel off
//  cfg_err     out  1           1-cycle pulse: accepted request had cfg_ch >= NUM_CH
//  busy        out  1           a config is pending application
//  tick        out  NUM_CH      per-channel 1-cycle strobe, registered
//  tick_count  out  NUM_CH*8    per-channel 8-bit tick counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): all cnt=0, div=0 (all channels off), tick=0, cfg_ready=1, busy=0,
//   cfg_err=0, tick_count=0, FSM=IDLE. A reset mid-config discards the pending config.
//  Channel i is active when div[i]!=0 and run=1. Each active cycle:
//   cnt==0 -> tick[i]<=1, cnt<=div[i]-1;  else tick[i]<=0, cnt<=cnt-1.
//   Inactive -> tick[i]<=0; cnt holds if run=0, cnt<=0 if div[i]==0.
//  Latency: first tick one cycle after the channel becomes active; then a period of exactly D.
//   D=1 -> tick high continuously.
//  run low->high resumes from the held cnt with no extra or lost tick.
//  Config FSM: IDLE, PEND.
//   IDLE: cfg_ready=1. Handshake = cfg_valid&cfg_ready.
//    - cfg_ch out of range: drop request, cfg_err=1 next cycle, stay IDLE.
//    - cfg_ch valid: latch {ch,div} into a shadow register, go to PEND.
//   PEND: cfg_ready=0, busy=1. Apply the shadow to div[ch] on the first cycle in which one holds:
//    (a) target channel inactive (off, or run=0), or
//    (b) target cnt==0 and run=1 (reload boundary), or
//    (c) cfg_div==0 (turn off: applied at once, cnt<=0, no tick that cycle).
//    On apply, return to IDLE; cfg_ready=1 from the next cycle.
//  Same-cycle boundary + apply in case (b): the tick for that cycle still fires.
//   The reload uses the NEW D (cnt<=Dnew-1).
//  Turning a channel on from off: the first tick comes the cycle after apply, with run=1.
//  Only one config is outstanding at a time. cfg_* inputs are ignored while cfg_ready=0.
//  Untargeted channels are never disturbed by a config operation.
// CONFIGURATION
//  TICK_COUNT_EN defined: tick_count[8i+:8] increments (wraps 255->0) on each tick[i] pulse.
//   It clears on reset and when channel i is set to D=0.
//  TICK_COUNT_EN undefined: no counter registers; tick_count is driven to constant 0.
// TESTING
//  1 reset, cfg ch0 D=4, run=1 -> ticks at cycles +1,+5,+9 after apply; all other tick=0.
//  2 ch1 D=3 running; cfg ch1 D=5 mid-period -> busy until cnt==0.
//    Old period completes, next gap=5, then cfg_ready=1.
//  3 ch2 D=2 running; drop run for 7 cycles -> no ticks, cnt held.
//    Restore run -> phase continues, no double tick.
//  4 cfg_ch=NUM_CH with valid -> cfg_err pulse 1 cycle, no state change, cfg_ready stays 1.
//  5 cfg ch0 D=0 while ticking -> tick stops next cycle, tick_count[7:0]=0 (TICK_COUNT_EN).
//    Also: D=1 gives continuous tick.
//  6 assert reset during PEND -> immediate outputs at reset values.
//    After release, old shadow is not applied; 256 ticks of D=1 wrap tick_count to 0.

Source files
------------

// File: rtl/tick_scheduler.sv
// Programmable multi-channel clock-enable (tick) generator with a valid/ready reprogramming port.
// Define TICK_COUNT_EN to add per-channel 8-bit tick counters on tick_count; otherwise it reads 0.
module tick_scheduler #(
   parameter  int NUM_CH = 4,
   parameter  int DIV_W  = 16,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [DIV_W-1:0]      cfg_div,
   output logic                  cfg_err,
   output logic                  busy,
   output logic [NUM_CH-1:0]     tick,
   output logic [NUM_CH*8-1:0]   tick_count
);

   localparam logic [0:0]       STATE_IDLE = 1'b0;
   localparam logic [0:0]       STATE_PEND = 1'b1;
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

   logic [0:0]        state_reg;
   logic [CH_W-1:0]   sh_ch_reg;
   logic [DIV_W-1:0]  sh_div_reg;
   logic              cfg_err_reg;

   logic              handshake;
   logic              ch_bad;
   logic [NUM_CH-1:0] active_vec;
   logic [NUM_CH-1:0] apply_vec;
   logic              apply_any;

   assign cfg_ready = (state_reg == STATE_IDLE);
   assign busy      = (state_reg == STATE_PEND);
   assign cfg_err   = cfg_err_reg;
   assign handshake = cfg_valid && cfg_ready;
   assign ch_bad    = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
   assign apply_any = |apply_vec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= STATE_IDLE;
         sh_ch_reg   <= '0;
         sh_div_reg  <= '0;
         cfg_err_reg <= 1'b0;
      end else begin
         cfg_err_reg <= handshake && ch_bad;
         case (state_reg)
            STATE_IDLE: begin
               if (handshake && !ch_bad) begin
                  sh_ch_reg  <= cfg_ch;
                  sh_div_reg <= cfg_div;
                  state_reg  <= STATE_PEND;
               end
            end
            default: begin
               if (apply_any) begin
                  state_reg <= STATE_IDLE;
               end
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DIV_W-1:0] div_reg, div_next;
         logic [DIV_W-1:0] cnt_reg, cnt_next;
         logic             tick_reg, tick_next;

         assign active_vec[gi] = (div_reg != '0) && run;
         // Apply only at a safe point: channel idle, at its reload boundary, or being switched off.
         assign apply_vec[gi]  = busy && (sh_ch_reg == CH_W'(gi)) &&
                                 (!active_vec[gi] || (cnt_reg == '0) || (sh_div_reg == '0));
         assign tick[gi]       = tick_reg;

         always_comb begin
            div_next  = div_reg;
            cnt_next  = cnt_reg;
            tick_next = 1'b0;
            if (apply_vec[gi]) begin
               div_next = sh_div_reg;
               if (sh_div_reg == '0) begin
                  cnt_next = '0;
               end else if (active_vec[gi]) begin
                  tick_next = 1'b1;
                  cnt_next  = sh_div_reg - DIV_ONE;
               end
            end else if (active_vec[gi]) begin
               if (cnt_reg == '0) begin
                  tick_next = 1'b1;
                  cnt_next  = div_reg - DIV_ONE;
               end else begin
                  cnt_next  = cnt_reg - DIV_ONE;
               end
            end else if (div_reg == '0) begin
               cnt_next = '0;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               div_reg  <= '0;
               cnt_reg  <= '0;
               tick_reg <= 1'b0;
            end else begin
               div_reg  <= div_next;
               cnt_reg  <= cnt_next;
               tick_reg <= tick_next;
            end
         end

`ifdef TICK_COUNT_EN
         logic [7:0] tc_reg;
         // Counts in step with tick so the count always matches the pulses already seen.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               tc_reg <= 8'd0;
            end else if (apply_vec[gi] && (sh_div_reg == '0)) begin
               tc_reg <= 8'd0;
            end else if (tick_next) begin
               tc_reg <= tc_reg + 8'd1;
            end
         end
         assign tick_count[8*gi +: 8] = tc_reg;
`endif
      end
   endgenerate

`ifndef TICK_COUNT_EN
   assign tick_count = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (3 channels so an out-of-range channel select is reachable).
module tb_tick_scheduler;
   localparam int NUM_CH = 3;
   localparam int DIV_W  = 16;
   localparam int CH_W   = 2;
`ifdef TICK_COUNT_EN
   localparam bit TC = 1'b1;
`else
   localparam bit TC = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                run = 1'b0;
   logic                cfg_valid = 1'b0;
   logic [CH_W-1:0]     cfg_ch = '0;
   logic [DIV_W-1:0]    cfg_div = '0;
   logic                cfg_ready, cfg_err, busy;
   logic [NUM_CH-1:0]   tick;
   logic [NUM_CH*8-1:0] tick_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tick_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_err    (cfg_err),
      .busy       (busy),
      .tick       (tick),
      .tick_count (tick_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expected);
      checks++;
      assert (obs === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expected);
      end
   endtask

   task automatic send(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] d);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = d;
      step();
      cfg_valid = 1'b0;
      cfg_div   = 16'h0007;
   endtask

   initial begin
      logic [8:0] exp1;
      logic [4:0] exp2;
      logic [3:0] exp3;
      int n;

      // reset state
      #3;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_count", 32'(tick_count), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // ch0 D=4: ticks +1,+5,+9 after apply
      run = 1'b1;
      send(2'd0, 16'd4);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(cfg_ready), 32'd0);
      chk("t1_tick_hs", 32'(tick), 32'd0);
      step();
      chk("t1_busy_apply", 32'(busy), 32'd0);
      chk("t1_ready_apply", 32'(cfg_ready), 32'd1);
      chk("t1_tick_apply", 32'(tick), 32'd0);
      exp1 = 9'b100010001;
      for (int k = 1; k <= 9; k++) begin
         step();
         $display("t1 cycle +%0d tick=%b", k, tick);
         chk("t1_tick", 32'(tick), {29'd0, 2'b00, exp1[k-1]});
      end
      chk("t1_count", 32'(tick_count[7:0]), TC ? 32'd3 : 32'd0);

      // ch0 D=0 while ticking: off immediately, counter cleared
      send(2'd0, 16'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_tick_hs", 32'(tick), 32'd0);
      step();
      chk("t5_busy_apply", 32'(busy), 32'd0);
      chk("t5_count_clr", 32'(tick_count), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t5_off_tick", 32'(tick), 32'd0);
      end

      // ch0 D=1: continuous tick
      send(2'd0, 16'd1);
      chk("t5b_tick_hs", 32'(tick), 32'd0);
      step();
      chk("t5b_tick_apply", 32'(tick), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t5b_cont", 32'(tick), 32'd1);
      end

      // out-of-range channel: cfg_err pulse, nothing else
      cfg_valid = 1'b1;
      cfg_ch    = 2'd3;
      cfg_div   = 16'd9;
      step();
      cfg_valid = 1'b0;
      $display("t4 err=%b ready=%b busy=%b", cfg_err, cfg_ready, busy);
      chk("t4_err", 32'(cfg_err), 32'd1);
      chk("t4_ready", 32'(cfg_ready), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_tick", 32'(tick), 32'd1);
      step();
      chk("t4_err_pulse", 32'(cfg_err), 32'd0);
      chk("t4_tick2", 32'(tick), 32'd1);

      // ch1 D=3 then reprogram to D=5 mid-period
      send(2'd1, 16'd3);
      chk("t2_busy_hs", 32'(busy), 32'd1);
      chk("t2_tick_hs", 32'(tick), 32'd1);
      step();
      chk("t2_busy_apply", 32'(busy), 32'd0);
      chk("t2_tick_apply", 32'(tick), 32'd1);
      step();
      chk("t2_first", 32'(tick), 32'd3);
      cfg_valid = 1'b1;
      cfg_ch    = 2'd1;
      cfg_div   = 16'd5;
      step();
      cfg_ch    = 2'd2;     // must be ignored while cfg_ready=0
      cfg_div   = 16'd2;
      chk("t2_busy_wait", 32'(busy), 32'd1);
      chk("t2_ready_wait", 32'(cfg_ready), 32'd0);
      chk("t2_tick_mid", 32'(tick), 32'd1);
      step();
      cfg_valid = 1'b0;
      chk("t2_busy_wait2", 32'(busy), 32'd1);
      chk("t2_tick_mid2", 32'(tick), 32'd1);
      step();
      chk("t2_boundary", 32'(tick), 32'd3);
      chk("t2_busy_done", 32'(busy), 32'd0);
      chk("t2_ready_done", 32'(cfg_ready), 32'd1);
      exp2 = 5'b10000;
      for (int k = 1; k <= 5; k++) begin
         step();
         $display("t2 cycle +%0d tick=%b", k, tick);
         chk("t2_newgap", 32'(tick), {29'd0, 1'b0, exp2[k-1], 1'b1});
      end

      // ch2 D=2, pause run at cnt=1 for 7 cycles, resume
      send(2'd2, 16'd2);
      step();
      chk("t3_apply", 32'(tick[2]), 32'd0);
      step();
      chk("t3_p0", 32'(tick[2]), 32'd1);
      step();
      chk("t3_p1", 32'(tick[2]), 32'd0);
      step();
      chk("t3_p2", 32'(tick[2]), 32'd1);
      run = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("t3_frozen", 32'(tick), 32'd0);
      end
      run = 1'b1;
      exp3 = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         $display("t3 resume +%0d tick2=%b", k + 1, tick[2]);
         chk("t3_resume", 32'(tick[2]), {31'd0, exp3[k]});
      end

      // reset while a config is pending
      send(2'd2, 16'd6);
      chk("t6_pend", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_tick", 32'(tick), 32'd0);
      chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_count", 32'(tick_count), 32'd0);
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t6_no_shadow", 32'(tick), 32'd0);
      end

      // 256 ticks of D=1 wrap the counter
      send(2'd0, 16'd1);
      step();
      n = 0;
      for (int k = 0; k < 255; k++) begin
         step();
         if (tick[0]) n++;
      end
      chk("t6_count255", 32'(tick_count[7:0]), TC ? 32'd255 : 32'd0);
      step();
      if (tick[0]) n++;
      $display("t6 ticks=%0d count=%0d", n, tick_count[7:0]);
      chk("t6_wrap", 32'(tick_count[7:0]), 32'd0);
      chk("t6_nticks", 32'(n), 32'd256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
